mult_32_bit_seq: RTL and testbench

MULT_32_BIT_SEQ -- requirements
Module: mult_32_bit_seq

---
 rtl/mult_32_bit_seq_if.sv | 22 ++
 rtl/mult_32_bit_seq.sv | 93 +++++++++
 tb/tb_mult_32_bit_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mult_32_bit_seq_if.sv
// Operand/result bundle for the sequential 32x32 multiplier.
// The master drives operands and start; the slave returns status and the 64-bit product.
interface mult_32_bit_seq_if;
    logic        start;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_32_bit_seq.sv
// Radix-2 shift-add multiplier: 32 iterations on operand magnitudes, sign applied
// to the 64-bit product on the final step. Supports unsigned and two's-complement modes.
module mult_32_bit_seq (
    input  logic               clk,
    input  logic               reset,
    mult_32_bit_seq_if.slave   mul
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] sum;
    logic [63:0] step;

    // Negating 0x80000000 yields 0x80000000, which is the correct magnitude read as unsigned.
    assign mag_a = (mul.signed_mode && mul.a[31]) ? (32'd0 - mul.a) : mul.a;
    assign mag_b = (mul.signed_mode && mul.b[31]) ? (32'd0 - mul.b) : mul.b;

    // Upper 33 bits hold the carry of the add so the shift never loses it.
    assign sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign step = {sum, acc_q[31:1]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (mul.start) begin
                    state_d = RUN;
                    mcand_d = mag_a;
                    acc_d   = {32'd0, mag_b};
                    cnt_d   = 5'd0;
                    sign_d  = mul.signed_mode & (mul.a[31] ^ mul.b[31]);
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    {hi_d, lo_d} = sign_q ? (64'd0 - step) : step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= 64'd0;
            mcand_q <= 32'd0;
            cnt_q   <= 5'd0;
            sign_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mul.busy = (state_q == RUN);
    assign mul.done = (state_q == DONE);
    assign mul.hi   = hi_q;
    assign mul.lo   = lo_q;
endmodule

// File: tb/tb_mult_32_bit_seq.sv
// Directed and random checks of the sequential multiplier against a plain-arithmetic model.
module tb_mult_32_bit_seq;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mult_32_bit_seq_if mif ();

    mult_32_bit_seq dut (
        .clk   (clk),
        .reset (reset),
        .mul   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic sm);
        logic [63:0] xe, ye;
        xe = sm ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sm ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one operation whose start is accepted on the next edge; optionally pokes
    // start with a=b=1 at RUN cycle poke. Returns at the IDLE cycle after DONE.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                          input int poke, input string tag);
        logic [63:0] exp;
        int bad;
        exp = model(av, bv, sm);
        mif.start = 1'b1;
        mif.a = av;
        mif.b = bv;
        mif.signed_mode = sm;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (mif.busy !== 1'b1 || mif.done !== 1'b0) bad++;
            if (i == poke) begin
                mif.start = 1'b1;
                mif.a = 32'd1;
                mif.b = 32'd1;
            end else begin
                mif.start = 1'b0;
                mif.a = $urandom;
                mif.b = $urandom;
                mif.signed_mode = 1'($urandom);
            end
        end
        mif.start = 1'b0;
        check({tag, "_busywin"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({tag, "_done"}, {63'd0, mif.done}, 64'd1);
        check({tag, "_busy_off"}, {63'd0, mif.busy}, 64'd0);
        check({tag, "_prod"}, {mif.hi, mif.lo}, exp);
        @(negedge clk);
        check({tag, "_done_off"}, {62'd0, mif.done, mif.busy}, 64'd0);
        $display("op %s a=%h b=%h sm=%0d hi=%h lo=%h exp=%h", tag, av, bv, sm,
                 mif.hi, mif.lo, exp);
    endtask

    initial begin
        int bad;
        int pulses;
        logic [31:0] ra, rb;
        reset = 1'b1;
        mif.start = 1'b0;
        mif.signed_mode = 1'b0;
        mif.a = 32'hDEAD_BEEF;
        mif.b = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        check("reset_state", {mif.hi, mif.lo}, 64'd0);
        check("reset_flags", {62'd0, mif.busy, mif.done}, 64'd0);

        // Start asserted on the very first non-reset edge.
        reset = 1'b0;
        run_op(32'd3, 32'd5, 1'b0, -1, "u_small");
        check("u_small_lo", {32'd0, mif.lo}, 64'h0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "u_max");
        check("u_max_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1, -1, "s_mixed");
        check("s_mixed_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, "s_min");
        check("s_min_hilo", {mif.hi, mif.lo}, 64'h4000_0000_0000_0000);
        run_op(32'd0, 32'hFFFF_FFFF, 1'b1, -1, "zero");
        run_op(32'h8000_0000, 32'd1, 1'b1, -1, "s_min_one");

        // Start poked mid-RUN must be ignored; no extra done afterwards.
        run_op(32'd7, 32'd6, 1'b0, 10, "busy_start");
        check("busy_start_lo", {mif.hi, mif.lo}, 64'h2A);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done !== 1'b0 || mif.busy !== 1'b0) bad++;
        end
        check("busy_start_quiet", 64'(bad), 64'd0);

        for (int n = 0; n < 8; n++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'($urandom), -1, $sformatf("rand%0d", n));
        end

        // Reset at RUN cycle 16 aborts and clears the result.
        mif.start = 1'b1;
        mif.a = 32'h1234_5678;
        mif.b = 32'h1234_5678;
        mif.signed_mode = 1'b0;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_flags", {62'd0, mif.busy, mif.done}, 64'd0);
        check("rst_mid_hilo", {mif.hi, mif.lo}, 64'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done !== 1'b0 || mif.busy !== 1'b0) bad++;
        end
        check("rst_mid_quiet", 64'(bad), 64'd0);
        $display("op rst_mid hi=%h lo=%h", mif.hi, mif.lo);

        // Start held high: accepted every 34 cycles.
        mif.start = 1'b1;
        mif.a = 32'd2;
        mif.b = 32'd3;
        mif.signed_mode = 1'b0;
        bad = 0;
        pulses = 0;
        for (int c = 0; c < 102; c++) begin
            @(negedge clk);
            if (mif.done !== ((c % 34) == 32)) bad++;
            if (mif.done === 1'b1) begin
                pulses++;
                check($sformatf("b2b_prod%0d", pulses), {mif.hi, mif.lo}, 64'd6);
                $display("op b2b pulse=%0d cycle=%0d hi=%h lo=%h", pulses, c, mif.hi, mif.lo);
            end
        end
        mif.start = 1'b0;
        check("b2b_timing", 64'(bad), 64'd0);
        check("b2b_pulses", 64'(pulses), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
